// File: rtl/mac_pkg.sv
// Shared MAC definitions: the rounding-mode encoding and the signed saturation
// limits of an n-bit two's complement result.
package mac_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'b00,  // floor
        RND_HALF_UP   = 2'b01,  // round half toward +inf
        RND_HALF_EVEN = 2'b10,  // round half to even
        RND_ZERO      = 2'b11   // round toward zero
    } rnd_mode_e;

    // Largest value representable in n-bit two's complement.
    function automatic longint sat_max(input int unsigned n);
        return (longint'(1) <<< (n - 1)) - longint'(1);
    endfunction

    // Most negative value representable in n-bit two's complement.
    function automatic longint sat_min(input int unsigned n);
        return -(longint'(1) <<< (n - 1));
    endfunction

endpackage

// File: rtl/round_sat_core.sv
// Combinational round/saturate datapath, split into its two pipeline halves.
//   Increment half : acc, mode -> sum_c (acc sign-extended by one bit plus the
//                    rounding increment), resid_c (dropped fraction bits).
//   Clamp half     : sum -> res_c (sum >>> Q clamped to N bits), sat_c.
// Parameters: N result width, Q result fraction bits (1 <= Q < N).
module round_sat_core
    import mac_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 8
) (
    input  logic [2*N-1:0] acc,
    input  logic [1:0]     mode,
    output logic [2*N:0]   sum_c,
    output logic [Q-1:0]   resid_c,
    input  logic [2*N:0]   sum,
    output logic [N-1:0]   res_c,
    output logic           sat_c
);

    localparam int unsigned ACC_W = 2 * N;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned T_W   = SUM_W - Q;
    localparam int unsigned HI_W  = T_W - N + 1;

    localparam logic [SUM_W-1:0] HALF    = SUM_W'(1) << (Q - 1);
    localparam logic [SUM_W-1:0] ONES    = (SUM_W'(1) << Q) - SUM_W'(1);
    localparam logic [N-1:0]     RES_MAX = N'(sat_max(N));
    localparam logic [N-1:0]     RES_MIN = N'(sat_min(N));

    logic [SUM_W-1:0]        inc;
    logic signed [SUM_W-1:0] sum_s;
    logic [T_W-1:0]          t;
    logic [HI_W-1:0]         hi;

    // Rounding increment; the extra sum bit keeps the add from overflowing.
    always_comb begin
        inc = '0;
        case (rnd_mode_e'(mode))
            RND_TRUNC:     inc = '0;
            RND_HALF_UP:   inc = HALF;
            // Half minus one, plus the kept LSB: exact ties carry only from odd.
            RND_HALF_EVEN: inc = HALF - SUM_W'(1) + SUM_W'(acc[Q]);
            // Negative values are biased up so the floor shift becomes a ceiling.
            RND_ZERO:      inc = acc[ACC_W-1] ? ONES : '0;
            default:       inc = '0;
        endcase
        sum_c   = {acc[ACC_W-1], acc} + inc;
        resid_c = acc[Q-1:0];
    end

    // Shift and clamp: t fits in N bits iff its bits above N-2 are all equal.
    always_comb begin
        sum_s = $signed(sum);
        t     = T_W'(sum_s >>> Q);
        hi    = t[T_W-1:N-1];
        sat_c = (hi != '0) && (hi != '1);
        res_c = t[N-1:0];
        if (sat_c) begin
            res_c = t[T_W-1] ? RES_MIN : RES_MAX;
        end
    end

endmodule

// File: rtl/round_sat_pipe.sv
// Two-stage valid/ready pipeline converting a 2N-bit accumulator (2Q fraction
// bits) into a rounded, saturated N-bit result (Q fraction bits).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake (in_ready combinational from out_ready)
//   in_acc, in_mode, in_err    accumulator word, per-beat rounding mode, upstream error
//   out_valid/out_ready        output handshake
//   out_res, out_resid         rounded result, dropped fraction bits
//   out_sat, out_err           clamp flag, delayed upstream error
//   sat_sticky, sticky_clr     sticky saturation status and its clear
// Build option: define ROUND_SAT_STICKY_EN to enable sat_sticky; otherwise it
// stays 0 and sticky_clr has no effect.
module round_sat_pipe
    import mac_pkg::*;
#(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_acc,
    input  logic [1:0]     in_mode,
    input  logic           in_err,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_res,
    output logic [Q-1:0]   out_resid,
    output logic           out_sat,
    output logic           out_err,
    output logic           sat_sticky,
    input  logic           sticky_clr
);

    localparam int unsigned ACC_W = 2 * N;
    localparam int unsigned SUM_W = ACC_W + 1;

    logic             s1_valid_q,  s1_valid_d;
    logic [SUM_W-1:0] s1_sum_q,    s1_sum_d;
    logic [Q-1:0]     s1_resid_q,  s1_resid_d;
    logic             s1_err_q,    s1_err_d;

    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_res_q,   out_res_d;
    logic [Q-1:0]     out_resid_q, out_resid_d;
    logic             out_sat_q,   out_sat_d;
    logic             out_err_q,   out_err_d;
    logic             sat_sticky_q, sat_sticky_d;

    logic             s2_adv_c;
    logic             in_ready_c;
    logic [SUM_W-1:0] core_sum_c;
    logic [Q-1:0]     core_resid_c;
    logic [N-1:0]     core_res_c;
    logic             core_sat_c;

    round_sat_core #(
        .N (N),
        .Q (Q)
    ) u_core (
        .acc     (in_acc),
        .mode    (in_mode),
        .sum_c   (core_sum_c),
        .resid_c (core_resid_c),
        .sum     (s1_sum_q),
        .res_c   (core_res_c),
        .sat_c   (core_sat_c)
    );

    // Stage 2 can take a beat when empty or draining this cycle.
    assign s2_adv_c   = ~out_valid_q | out_ready;
    assign in_ready_c = ~s1_valid_q | s2_adv_c;

    // Next-state for both stages and the sticky flag.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sum_d     = s1_sum_q;
        s1_resid_d   = s1_resid_q;
        s1_err_d     = s1_err_q;
        out_valid_d  = out_valid_q;
        out_res_d    = out_res_q;
        out_resid_d  = out_resid_q;
        out_sat_d    = out_sat_q;
        out_err_d    = out_err_q;
        sat_sticky_d = sat_sticky_q;

        if (in_ready_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sum_d   = core_sum_c;
                s1_resid_d = core_resid_c;
                s1_err_d   = in_err;
            end
        end

        if (s2_adv_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_res_d   = core_res_c;
                out_resid_d = s1_resid_q;
                out_sat_d   = core_sat_c;
                out_err_d   = s1_err_q;
            end
        end

`ifdef ROUND_SAT_STICKY_EN
        // Set has priority over clear.
        sat_sticky_d = (sat_sticky_q & ~sticky_clr)
                     | (out_valid_q & out_ready & out_sat_q);
`else
        // Nothing sets the flag, so it remains at its reset value of 0.
        sat_sticky_d = sat_sticky_q & ~sticky_clr;
`endif
    end

    // Pipeline and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s1_resid_q   <= '0;
            s1_err_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_res_q    <= '0;
            out_resid_q  <= '0;
            out_sat_q    <= 1'b0;
            out_err_q    <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sum_q     <= s1_sum_d;
            s1_resid_q   <= s1_resid_d;
            s1_err_q     <= s1_err_d;
            out_valid_q  <= out_valid_d;
            out_res_q    <= out_res_d;
            out_resid_q  <= out_resid_d;
            out_sat_q    <= out_sat_d;
            out_err_q    <= out_err_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    assign in_ready   = in_ready_c;
    assign out_valid  = out_valid_q;
    assign out_res    = out_res_q;
    assign out_resid  = out_resid_q;
    assign out_sat    = out_sat_q;
    assign out_err    = out_err_q;
    assign sat_sticky = sat_sticky_q;

endmodule
